// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single Data_Memory port between the ICache refill master
//   (port 0) and the DCache write-back/refill master (port 1). One complete
//   enable..ack transaction is granted at a time. Ties are broken either
//   round-robin (ARB_MODE=0) or with port 1 always winning (ARB_MODE=1).
//
// Ports
//   clk_i, rst_i             clock (posedge) and asynchronous active-low reset
//   mX_enable_i/write_i      request and direction from master X (held until ack)
//   mX_addr_i/data_i         line address and write data from master X
//   mX_data_o                read data to master X (mem_data_i, always)
//   mX_ack_o                 completion strobe to master X
//   mem_enable_o/write_o     request and direction to Data_Memory
//   mem_addr_o/data_o        address and write data to Data_Memory
//   mem_data_i/ack_i         read data and completion from Data_Memory
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int ARB_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;

    // Read data is broadcast; masters qualify it with their own ack.
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

    // last_grant resets to 1 so port 0 wins the first round-robin tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;

        case (state_q)
            // IDLE drives nothing to memory, so every transaction is separated
            // by an enable-low cycle; a stray mem_ack_i here is dropped.
            IDLE: begin
                if (m0_enable_i && m1_enable_i) begin
                    if (ARB_MODE == 1) begin
                        state_d = GRANT1;
                    end else if (last_grant_q) begin
                        state_d = GRANT0;
                    end else begin
                        state_d = GRANT1;
                    end
                end else if (m0_enable_i) begin
                    state_d = GRANT0;
                end else if (m1_enable_i) begin
                    state_d = GRANT1;
                end
            end

            // Enable follows the master so an abort is visible to memory in
            // the same cycle the master withdraws. Completion wins over abort.
            GRANT0: begin
                mem_enable_o = m0_enable_i;
                mem_write_o  = m0_write_i;
                mem_addr_o   = m0_addr_i;
                mem_data_o   = m0_data_i;
                m0_ack_o     = mem_ack_i;
                if (mem_ack_i) begin
                    last_grant_d = 1'b0;
                    state_d      = IDLE;
                end else if (!m0_enable_i) begin
                    state_d = IDLE;
                end
            end

            GRANT1: begin
                mem_enable_o = m1_enable_i;
                mem_write_o  = m1_write_i;
                mem_addr_o   = m1_addr_i;
                mem_data_o   = m1_data_i;
                m1_ack_o     = mem_ack_i;
                if (mem_ack_i) begin
                    last_grant_d = 1'b1;
                    state_d      = IDLE;
                end else if (!m1_enable_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Instance dut is round-robin, instance
//   dut_fp is fixed priority; both share the same stimulus. Inputs change 1ns
//   after the rising edge, outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk_i;
    logic          rst_i;
    logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i, mem_data_i;
    logic          mem_ack_i;

    logic [DW-1:0] m0_data_o, m1_data_o, mem_data_o;
    logic          m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;

    logic [DW-1:0] fp_m0_data_o, fp_m1_data_o, fp_mem_data_o;
    logic          fp_m0_ack_o, fp_m1_ack_o, fp_mem_enable_o, fp_mem_write_o;
    logic [AW-1:0] fp_mem_addr_o;

    int n_checks;
    int n_fail;

    localparam logic [DW-1:0] RD_PAT = {8{32'hCAFE_0000}} ^ 256'h1234_5678;
    localparam logic [DW-1:0] WR_PAT = {8{32'hA5A5_0F0F}};

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut_fp (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_data_o(fp_m0_data_o), .m0_ack_o(fp_m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_data_o(fp_m1_data_o), .m1_ack_o(fp_m1_ack_o),
        .mem_enable_o(fp_mem_enable_o), .mem_write_o(fp_mem_write_o), .mem_addr_o(fp_mem_addr_o),
        .mem_data_o(fp_mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic drive_point();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_point();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
        mem_data_i  = '0;   mem_ack_i  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b0;
        drive_point();
        drive_point();
        rst_i = 1'b1;
    endtask

    // Reset state, then a single port 0 read with a 10-cycle memory latency.
    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b0;
        drive_point();
        check_point();
        n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %0b want 0", mem_enable_o); end
        n_checks++; if (mem_addr_o !== '0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
        n_checks++; if ({m0_ack_o, m1_ack_o, mem_write_o} !== 3'b000) begin n_fail++; $display("FAIL rst_acks: got %b want 000", {m0_ack_o, m1_ack_o, mem_write_o}); end
        drive_point();
        rst_i = 1'b1;
    endtask

    task automatic test_single_read();
        drive_point();                       // cycle 1: request seen in IDLE
        m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0400;
        check_point();
        n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL t1_idle_en: got %0b want 0", mem_enable_o); end
        for (int i = 0; i < 9; i++) begin    // cycles 2..10 granted, no ack yet
            drive_point();
            check_point();
            n_checks++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h0000_0400 || m0_ack_o !== 1'b0)
                begin n_fail++; $display("FAIL t1_grant c%0d: en=%0b addr=%h ack=%0b want 1/00000400/0", i + 2, mem_enable_o, mem_addr_o, m0_ack_o); end
        end
        drive_point();                       // ack cycle
        mem_ack_i = 1'b1; mem_data_i = RD_PAT;
        check_point();
        n_checks++; if (m0_ack_o !== 1'b1) begin n_fail++; $display("FAIL t1_ack: got %0b want 1", m0_ack_o); end
        n_checks++; if (m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL t1_m1ack: got %0b want 0", m1_ack_o); end
        n_checks++; if (m0_data_o !== RD_PAT) begin n_fail++; $display("FAIL t1_data: got %h want %h", m0_data_o, RD_PAT); end
        drive_point();
        mem_ack_i = 1'b0; m0_enable_i = 1'b0;
        check_point();
        n_checks++; if (mem_enable_o !== 1'b0 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL t1_after: en=%0b ack=%0b want 0/0", mem_enable_o, m0_ack_o); end
    endtask

    // Simultaneous requests after reset, round-robin: port 0 then port 1.
    task automatic test_rr_tie();
        do_reset();
        m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0400;
        m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h0000_1000; m1_data_i = WR_PAT;
        check_point();
        n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL t2_idle: got %0b want 0", mem_enable_o); end
        drive_point(); check_point();
        n_checks++; if (mem_addr_o !== 32'h0000_0400 || mem_write_o !== 1'b0 || m1_ack_o !== 1'b0)
            begin n_fail++; $display("FAIL t2_g0: addr=%h wr=%0b m1ack=%0b want 00000400/0/0", mem_addr_o, mem_write_o, m1_ack_o); end
        drive_point(); mem_ack_i = 1'b1; check_point();
        n_checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL t2_ack0: m0=%0b m1=%0b want 1/0", m0_ack_o, m1_ack_o); end
        drive_point(); mem_ack_i = 1'b0; m0_enable_i = 1'b0; check_point();
        n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL t2_gap: got %0b want 0", mem_enable_o); end
        drive_point(); check_point();
        n_checks++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h0000_1000 || mem_write_o !== 1'b1 || mem_data_o !== WR_PAT)
            begin n_fail++; $display("FAIL t2_g1: en=%0b addr=%h wr=%0b data=%h", mem_enable_o, mem_addr_o, mem_write_o, mem_data_o); end
        drive_point(); mem_ack_i = 1'b1; check_point();
        n_checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL t2_ack1: m1=%0b m0=%0b want 1/0", m1_ack_o, m0_ack_o); end
        drive_point(); mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    endtask

    // Port 1 write-back then refill with enable held; port 0 slots in between.
    task automatic test_back_to_back();
        do_reset();
        m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h0000_1000; m1_data_i = WR_PAT;
        drive_point();
        m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0400;
        check_point();
        n_checks++; if (mem_addr_o !== 32'h0000_1000 || mem_write_o !== 1'b1) begin n_fail++; $display("FAIL t3_wb: addr=%h wr=%0b want 00001000/1", mem_addr_o, mem_write_o); end
        drive_point(); mem_ack_i = 1'b1; check_point();
        n_checks++; if (m1_ack_o !== 1'b1) begin n_fail++; $display("FAIL t3_wb_ack: got %0b want 1", m1_ack_o); end
        drive_point(); mem_ack_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = 32'h0000_2000; check_point();
        n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL t3_gap1: got %0b want 0", mem_enable_o); end
        drive_point(); check_point();
        n_checks++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h0000_0400) begin n_fail++; $display("FAIL t3_m0: en=%0b addr=%h want 1/00000400", mem_enable_o, mem_addr_o); end
        drive_point(); mem_ack_i = 1'b1; check_point();
        n_checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL t3_m0_ack: m0=%0b m1=%0b want 1/0", m0_ack_o, m1_ack_o); end
        drive_point(); mem_ack_i = 1'b0; m0_enable_i = 1'b0; check_point();
        n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL t3_gap2: got %0b want 0", mem_enable_o); end
        drive_point(); check_point();
        n_checks++; if (mem_addr_o !== 32'h0000_2000 || mem_write_o !== 1'b0 || mem_enable_o !== 1'b1)
            begin n_fail++; $display("FAIL t3_refill: en=%0b addr=%h wr=%0b want 1/00002000/0", mem_enable_o, mem_addr_o, mem_write_o); end
        drive_point(); mem_ack_i = 1'b1; check_point();
        n_checks++; if (m1_ack_o !== 1'b1) begin n_fail++; $display("FAIL t3_refill_ack: got %0b want 1", m1_ack_o); end
        drive_point(); mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    endtask

    // Fixed-priority instance: port 1 wins every tie until it withdraws.
    task automatic test_fixed_priority();
        do_reset();
        m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0400;
        m1_enable_i = 1'b1; m1_addr_i = 32'h0000_1000;
        for (int k = 0; k < 2; k++) begin
            drive_point(); check_point();
            n_checks++; if (fp_mem_addr_o !== 32'h0000_1000 || fp_mem_enable_o !== 1'b1)
                begin n_fail++; $display("FAIL t4_grant%0d: en=%0b addr=%h want 1/00001000", k, fp_mem_enable_o, fp_mem_addr_o); end
            drive_point(); mem_ack_i = 1'b1; check_point();
            n_checks++; if (fp_m1_ack_o !== 1'b1 || fp_m0_ack_o !== 1'b0)
                begin n_fail++; $display("FAIL t4_ack%0d: m1=%0b m0=%0b want 1/0", k, fp_m1_ack_o, fp_m0_ack_o); end
            drive_point(); mem_ack_i = 1'b0;
            if (k == 1) m1_enable_i = 1'b0;
            check_point();
        end
        drive_point(); check_point();
        n_checks++; if (fp_mem_addr_o !== 32'h0000_0400 || fp_mem_enable_o !== 1'b1)
            begin n_fail++; $display("FAIL t4_m0: en=%0b addr=%h want 1/00000400", fp_mem_enable_o, fp_mem_addr_o); end
        drive_point(); mem_ack_i = 1'b1; check_point();
        n_checks++; if (fp_m0_ack_o !== 1'b1) begin n_fail++; $display("FAIL t4_m0_ack: got %0b want 1", fp_m0_ack_o); end
        drive_point(); mem_ack_i = 1'b0; m0_enable_i = 1'b0;
    endtask

    // Port 1 abort; last_grant stays 0 from the earlier port 0 transfer.
    task automatic test_abort();
        do_reset();
        m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0400;
        drive_point();
        drive_point(); mem_ack_i = 1'b1;
        drive_point(); mem_ack_i = 1'b0; m0_enable_i = 1'b0;
        m1_enable_i = 1'b1; m1_addr_i = 32'h0000_1000;
        for (int k = 0; k < 3; k++) begin
            drive_point(); check_point();
            n_checks++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h0000_1000)
                begin n_fail++; $display("FAIL t5_grant%0d: en=%0b addr=%h want 1/00001000", k, mem_enable_o, mem_addr_o); end
        end
        drive_point(); m1_enable_i = 1'b0; check_point();
        n_checks++; if (mem_enable_o !== 1'b0 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL t5_drop: en=%0b ack=%0b want 0/0", mem_enable_o, m1_ack_o); end
        drive_point(); m0_enable_i = 1'b1; m1_enable_i = 1'b1; check_point();
        n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL t5_idle: got %0b want 0", mem_enable_o); end
        drive_point(); check_point();
        n_checks++; if (mem_addr_o !== 32'h0000_1000 || mem_enable_o !== 1'b1)
            begin n_fail++; $display("FAIL t5_lastgrant: en=%0b addr=%h want 1/00001000", mem_enable_o, mem_addr_o); end
        drive_point(); m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    endtask

    // Async reset during GRANT0, then a spurious ack while idle.
    task automatic test_reset_mid_and_spurious_ack();
        do_reset();
        m0_enable_i = 1'b1; m0_write_i = 1'b1; m0_addr_i = 32'h0000_0400; m0_data_i = WR_PAT;
        drive_point(); check_point();
        n_checks++; if (mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL t6_grant: got %0b want 1", mem_enable_o); end
        drive_point();
        rst_i = 1'b0;
        #1;
        n_checks++; if ({mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o} !== 4'b0000 || mem_addr_o !== '0 || mem_data_o !== '0)
            begin n_fail++; $display("FAIL t6_async: en=%0b wr=%0b addr=%h data=%h", mem_enable_o, mem_write_o, mem_addr_o, mem_data_o); end
        m0_enable_i = 1'b0;
        drive_point();
        rst_i = 1'b1;
        drive_point(); mem_ack_i = 1'b1; check_point();
        n_checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || mem_enable_o !== 1'b0)
            begin n_fail++; $display("FAIL t6_spurious: m0=%0b m1=%0b en=%0b want 0/0/0", m0_ack_o, m1_ack_o, mem_enable_o); end
        drive_point(); mem_ack_i = 1'b0; check_point();
        n_checks++; if (mem_enable_o !== 1'b0 || mem_addr_o !== '0) begin n_fail++; $display("FAIL t6_stay: en=%0b addr=%h want 0/0", mem_enable_o, mem_addr_o); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_read();
        test_rr_tie();
        test_back_to_back();
        test_fixed_priority();
        test_abort();
        test_reset_mid_and_spurious_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
